fifo_rd_ctrl: RTL and testbench

Read-side pointer and status controller for the depth-8 asynchronous FIFO. It consumes the write pointer after the two-flop write-to-read synchronizer has brought it into the `r_clk` domain. It owns the read pointer in binary and Gray form and drives the RAM read address. It also produces registered empty, almost-empty, fill-level and sticky underflow status. Its Gray read pointer output feeds the read-to-write synchronizer.

---
 rtl/fifo_pkg.sv | 31 +++
 rtl/gray2bin_conv.sv | 19 +
 rtl/fifo_rd_ctrl.sv | 80 ++++++++
 tb/tb_fifo_rd_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the depth-8 asynchronous FIFO pointer logic.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package fifo_pkg;

    localparam int ADDR_WIDTH = 3;
    localparam int PTR_W      = ADDR_WIDTH + 1;

    // Binary to Gray for the low w bits of b; bits above w are cleared.
    function automatic logic [31:0] bin2gray(input logic [31:0] b, input int w);
        logic [31:0] mask;
        mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (b ^ (b >> 1)) & mask;
    endfunction

    // Gray to binary for the low w bits of g: each binary bit is the XOR of
    // every Gray bit at or above it.
    function automatic logic [31:0] gray2bin(input logic [31:0] g, input int w);
        logic [31:0] mask;
        logic [31:0] gm;
        logic [31:0] b;
        mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        gm   = g & mask;
        b    = '0;
        for (int i = 0; i < 32; i++) begin
            b[i] = ^(gm >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Gray-to-binary converter (XOR prefix from the MSB down); shared by both pointer controllers.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of gray.
// Ports: gray (W-bit Gray code in), bin (W-bit binary out).
module gray2bin_conv #(
    parameter int W = 4
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    always_comb begin
        bin = '0;
        for (int i = 0; i < W; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side pointer/status controller for the async FIFO: binary+Gray read pointer, RAM read address, empty/almost-empty/level/underflow.
// Latency: all outputs registered; a synchronized write-pointer change shows in r_empty/r_level one r_clk later.
// Backpressure: reads are accepted only while r_empty is low; a read while empty is dropped and sets sticky r_underflow.
// Ports: r_clk/r_rstn (clock, async active-low reset), r_en (read request), r_clr_err (clear underflow),
//        rq2_wptr (synchronized Gray write pointer), r_addr (RAM address), r_ptr (Gray read pointer to the write side),
//        r_empty, r_almost_empty, r_level, r_underflow (status).
module fifo_rd_ctrl #(
    parameter int ADDR_WIDTH = fifo_pkg::ADDR_WIDTH,
    parameter int AE_THRESH  = 2
) (
    input  logic                  r_clk,
    input  logic                  r_rstn,
    input  logic                  r_en,
    input  logic                  r_clr_err,
    input  logic [ADDR_WIDTH:0]   rq2_wptr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic [ADDR_WIDTH:0]   r_ptr,
    output logic                  r_empty,
    output logic                  r_almost_empty,
    output logic [ADDR_WIDTH:0]   r_level,
    output logic                  r_underflow
);

    import fifo_pkg::*;

    localparam int                    PTR_WIDTH = ADDR_WIDTH + 1;
    localparam logic [PTR_WIDTH-1:0]  AE_LIMIT  = PTR_WIDTH'(AE_THRESH);

    logic [PTR_WIDTH-1:0] rbin;
    logic [PTR_WIDTH-1:0] rbin_next;
    logic [PTR_WIDTH-1:0] rgray_next;
    logic [PTR_WIDTH-1:0] wbin;
    logic [PTR_WIDTH-1:0] level_next;
    logic                 rd_accept;

    gray2bin_conv #(
        .W (PTR_WIDTH)
    ) u_wptr_conv (
        .gray (rq2_wptr),
        .bin  (wbin)
    );

    // Gating on the registered r_empty keeps every output free of any
    // combinational path from r_en.
    always_comb begin
        rd_accept  = r_en & ~r_empty;
        rbin_next  = rbin + PTR_WIDTH'(rd_accept);
        rgray_next = PTR_WIDTH'(bin2gray(32'(rbin_next), PTR_WIDTH));
        // Modulo subtraction: the extra wrap bit distinguishes full (2^ADDR_WIDTH) from empty.
        level_next = wbin - rbin_next;
    end

    // The address is simply the low bits of the registered binary pointer.
    assign r_addr = rbin[ADDR_WIDTH-1:0];

    always_ff @(posedge r_clk or negedge r_rstn) begin
        if (!r_rstn) begin
            rbin           <= '0;
            r_ptr          <= '0;
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
            r_level        <= '0;
            r_underflow    <= 1'b0;
        end else begin
            rbin           <= rbin_next;
            r_ptr          <= rgray_next;
            // Gray compare including the wrap bit: equal means nothing left to read.
            r_empty        <= (rgray_next == rq2_wptr);
            r_almost_empty <= (level_next <= AE_LIMIT);
            r_level        <= level_next;
            // Set has priority over clear so a fresh fault is never lost.
            if (r_en & r_empty) begin
                r_underflow <= 1'b1;
            end else if (r_clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
module tb_fifo_rd_ctrl;

    logic       r_clk;
    logic       r_rstn;
    logic       r_en;
    logic       r_clr_err;
    logic [3:0] rq2_wptr;
    logic [2:0] r_addr;
    logic [3:0] r_ptr;
    logic       r_empty;
    logic       r_almost_empty;
    logic [3:0] r_level;
    logic       r_underflow;

    int checks = 0;
    int errors = 0;

    // Reference model: total writes made visible and total reads accepted,
    // as unbounded counts; the status follows from their difference.
    int m_wr;
    int m_rd;
    int m_level;
    bit m_empty;
    bit m_ae;
    bit m_uf;

    fifo_rd_ctrl #(
        .ADDR_WIDTH (3),
        .AE_THRESH  (2)
    ) dut (
        .r_clk          (r_clk),
        .r_rstn         (r_rstn),
        .r_en           (r_en),
        .r_clr_err      (r_clr_err),
        .rq2_wptr       (rq2_wptr),
        .r_addr         (r_addr),
        .r_ptr          (r_ptr),
        .r_empty        (r_empty),
        .r_almost_empty (r_almost_empty),
        .r_level        (r_level),
        .r_underflow    (r_underflow)
    );

    initial begin
        r_clk = 1'b0;
        forever #5 r_clk = ~r_clk;
    end

    function automatic logic [3:0] g4(input int n);
        logic [3:0] b;
        b = 4'(n % 16);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [13:0] exp_vec();
        return {m_empty, m_ae, 4'(m_level), g4(m_rd), 3'(m_rd % 8), m_uf};
    endfunction

    function automatic logic [13:0] act_vec();
        return {r_empty, r_almost_empty, r_level, r_ptr, r_addr, r_underflow};
    endfunction

    task automatic model_reset();
        m_wr = 0; m_rd = 0; m_level = 0;
        m_empty = 1'b1; m_ae = 1'b1; m_uf = 1'b0;
    endtask

    // Present one cycle of inputs, clock it, advance the model, sample at +1.
    task automatic cyc(input bit en, input bit clr, input int wr_total);
        r_en      = en;
        r_clr_err = clr;
        m_wr      = wr_total;
        rq2_wptr  = g4(wr_total);
        @(posedge r_clk);
        if (en && m_empty) m_uf = 1'b1;
        else if (clr)      m_uf = 1'b0;
        if (en && !m_empty) m_rd = m_rd + 1;
        m_level = m_wr - m_rd;
        m_empty = (m_level == 0);
        m_ae    = (m_level <= 2);
        #1;
    endtask

    task automatic do_reset();
        r_en = 1'b0; r_clr_err = 1'b0; rq2_wptr = 4'd0;
        r_rstn = 1'b0;
        @(posedge r_clk);
        #1 r_rstn = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        logic [13:0] rst_v;
        rst_v = {1'b1, 1'b1, 4'd0, 4'd0, 3'd0, 1'b0};
        r_en = 1'b0; r_clr_err = 1'b0; rq2_wptr = 4'd0;
        r_rstn = 1'b1;
        #2 r_rstn = 1'b0;
        #1;
        checks++;
        if (act_vec() !== rst_v) begin
            errors++; $display("FAIL reset_initial act=%h exp=%h", act_vec(), rst_v);
        end
        @(posedge r_clk);
        #1 r_rstn = 1'b1;
        model_reset();
        // Build some state, then assert reset between clock edges.
        cyc(1'b0, 1'b0, 3);
        cyc(1'b1, 1'b0, 3);
        checks++;
        if (act_vec() !== exp_vec()) begin
            errors++; $display("FAIL reset_prestate act=%h exp=%h", act_vec(), exp_vec());
        end
        r_en = 1'b1;
        #2 r_rstn = 1'b0;
        #1;
        checks++;
        if (act_vec() !== rst_v) begin
            errors++; $display("FAIL reset_async act=%h exp=%h", act_vec(), rst_v);
        end
        do_reset();
        checks++;
        if (act_vec() !== exp_vec()) begin
            errors++; $display("FAIL reset_release act=%h exp=%h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_fill_drain();
        cyc(1'b0, 1'b0, 4);
        checks++;
        if ({r_empty, r_level, r_almost_empty} !== {1'b0, 4'd4, 1'b0}) begin
            errors++; $display("FAIL fill_level act=%b/%0d/%b exp=0/4/0", r_empty, r_level, r_almost_empty);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 4);
            checks++;
            if ({r_level, r_addr, r_empty, r_almost_empty} !==
                {4'(3 - i), 3'(i + 1), 1'(i == 3), 1'((3 - i) <= 2)}) begin
                errors++;
                $display("FAIL drain_step%0d act=lvl%0d addr%0d e%b ae%b exp=lvl%0d addr%0d e%b ae%b",
                         i, r_level, r_addr, r_empty, r_almost_empty, 3 - i, i + 1, i == 3, (3 - i) <= 2);
            end
        end
    endtask

    task automatic test_underflow();
        cyc(1'b1, 1'b0, 4);
        checks++;
        if ({r_underflow, r_ptr} !== {1'b1, 4'b0110} || act_vec() !== exp_vec()) begin
            errors++; $display("FAIL underflow_set act=%h exp=%h", act_vec(), exp_vec());
        end
        cyc(1'b0, 1'b0, 4);
        checks++;
        if (r_underflow !== 1'b1) begin
            errors++; $display("FAIL underflow_hold act=%b exp=1", r_underflow);
        end
        cyc(1'b0, 1'b1, 4);
        checks++;
        if (r_underflow !== 1'b0) begin
            errors++; $display("FAIL underflow_clear act=%b exp=0", r_underflow);
        end
        cyc(1'b1, 1'b1, 4);
        checks++;
        if (r_underflow !== 1'b1) begin
            errors++; $display("FAIL underflow_set_wins act=%b exp=1", r_underflow);
        end
        cyc(1'b0, 1'b1, 4);
        checks++;
        if (act_vec() !== exp_vec()) begin
            errors++; $display("FAIL underflow_final act=%h exp=%h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_full_and_simultaneous();
        do_reset();
        cyc(1'b0, 1'b0, 8);
        checks++;
        if ({rq2_wptr, r_level, r_empty, r_almost_empty} !== {4'b1100, 4'd8, 1'b0, 1'b0}) begin
            errors++; $display("FAIL full_level act=lvl%0d e%b ae%b exp=lvl8 e0 ae0", r_level, r_empty, r_almost_empty);
        end
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8);
        checks++;
        if (r_level !== 4'd3) begin
            errors++; $display("FAIL simul_pre act=%0d exp=3", r_level);
        end
        cyc(1'b1, 1'b0, 10);
        checks++;
        if (r_level !== 4'd4 || act_vec() !== exp_vec()) begin
            errors++; $display("FAIL simul_read_plus2 act=%h exp=%h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int k = 0; k < 20; k++) begin
            cyc(1'b0, 1'b0, k + 1);
            cyc(1'b1, 1'b0, k + 1);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++; $display("FAIL wrap_read%0d act=%h exp=%h", k + 1, act_vec(), exp_vec());
            end
            if (k == 14) begin
                checks++;
                if (r_ptr !== 4'b1000) begin
                    errors++; $display("FAIL wrap_ptr15 act=%b exp=1000", r_ptr);
                end
            end
            if (k == 15) begin
                checks++;
                if ({r_ptr, r_addr, r_empty} !== {4'b0000, 3'd0, 1'b1}) begin
                    errors++; $display("FAIL wrap_ptr16 act=%b/%0d/%b exp=0000/0/1", r_ptr, r_addr, r_empty);
                end
            end
        end
    endtask

    task automatic test_random(input bit fast_writer, input int n);
        logic [3:0] prev;
        int         nw;
        int         inc;
        bit         en;
        bit         clr;
        do_reset();
        for (int c = 0; c < n; c++) begin
            prev = r_ptr;
            en   = 1'($urandom_range(0, 1));
            clr  = ($urandom_range(0, 9) == 0);
            if (fast_writer) inc = int'($urandom_range(0, 3));
            else             inc = ($urandom_range(0, 2) == 0) ? 1 : 0;
            nw = m_wr + inc;
            if (nw > m_rd + 8) nw = m_rd + 8;
            cyc(en, clr, nw);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++; $display("FAIL random%0d_cyc%0d act=%h exp=%h", fast_writer, c, act_vec(), exp_vec());
            end
            checks++;
            if ($countones(prev ^ r_ptr) > 1) begin
                errors++; $display("FAIL gray_step cyc%0d act=%b->%b exp=single-bit step", c, prev, r_ptr);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill_drain();
        test_underflow();
        test_full_and_simultaneous();
        test_wrap();
        test_random(1'b1, 300);
        test_random(1'b0, 300);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
